// File: rtl/alu_op_sequencer.sv
// Registered ALU-op decoder with RV32M multi-cycle step sequencing.
// Optional: define ALU_SEQ_FLUSH_EN to add a pipeline flush input.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic       flush,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] alu_op,
    output logic       md_sel,
    output logic [2:0] md_op,
    output logic       md_step,
    output logic       md_first,
    output logic       md_last,
    output logic       illegal,
    output logic       busy
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MD_RUN = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] lim;
    logic          is_div_q;
    logic          flush_w;
    logic          accept;
    logic          run;
    logic          at_last;

    logic [4:0]    d_alu;
    logic          d_md;
    logic          d_ill;

`ifdef ALU_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Decode of the instruction currently presented by the decode stage
    always_comb begin
        d_alu = 5'b00000;
        d_md  = 1'b0;
        d_ill = 1'b0;
        unique case (opcode)
            7'b0010011: begin
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 &&
                     funct7 != 7'h20)) begin
                    d_ill = 1'b1;
                end else begin
                    d_alu = {1'b1, (funct3 == 3'b101) & funct7[5], funct3};
                end
            end
            7'b0110011: begin
                unique case (funct7)
                    7'h00: d_alu = {2'b10, funct3};
                    7'h20: begin
                        if (funct3 == 3'b000 || funct3 == 3'b101) begin
                            d_alu = {2'b11, funct3};
                        end else begin
                            d_ill = 1'b1;
                        end
                    end
                    7'h01: d_md = 1'b1;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b1100011: d_alu = 5'b11000;
            7'b1100111: d_alu = 5'b10000;
            default: d_alu = 5'b00000;
        endcase
    end

    assign run      = (state == MD_RUN);
    assign lim      = is_div_q ? DIV_LAST : MUL_LAST;
    assign at_last  = (cnt == lim);
    assign in_ready = !flush_w &&
                      ((state == IDLE) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flush_w) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (accept) begin
            state_n = d_md ? MD_RUN : HOLD;
            cnt_n   = '0;
        end else begin
            unique case (state)
                MD_RUN: begin
                    if (at_last) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) state_n = IDLE;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_op   <= '0;
            md_sel   <= 1'b0;
            md_op    <= '0;
            illegal  <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                alu_op   <= d_alu;
                md_sel   <= d_md;
                md_op    <= d_md ? funct3 : 3'b000;
                illegal  <= d_ill;
                is_div_q <= funct3[2];
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign md_step   = run;
    assign md_first  = run && (cnt == '0);
    assign md_last   = run && at_last;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed scenarios plus random
// instructions checked against a rule-level reference model.
module tb_alu_op_sequencer;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       in_ready, out_valid, md_sel, md_step, md_first, md_last;
    logic       illegal, busy;
    logic [4:0] alu_op;
    logic [2:0] md_op;
`ifdef ALU_SEQ_FLUSH_EN
    logic       flush = 1'b0;
`endif

    alu_op_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ALU_SEQ_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_op(alu_op),
        .md_sel(md_sel),
        .md_op(md_op),
        .md_step(md_step),
        .md_first(md_first),
        .md_last(md_last),
        .illegal(illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] alu;
        logic       md;
        logic [2:0] mop;
        logic       ill;
        int         n;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rdy_mode = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Expected result straight from the instruction-class rules
    function automatic exp_t model(input logic [6:0] op,
                                   input logic [2:0] f3,
                                   input logic [6:0] f7);
        exp_t e;
        e.alu = 5'd0;
        e.md  = 1'b0;
        e.mop = 3'd0;
        e.ill = 1'b0;
        e.n   = 0;
        e.acc = 0;
        if (op == 7'h13) begin
            if ((f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
                e.ill = 1'b1;
            end else begin
                e.alu = 5'(16 + ((f3 == 3'd5 && f7 == 7'h20) ? 8 : 0) + f3);
            end
        end else if (op == 7'h33) begin
            if (f7 == 7'h00) begin
                e.alu = 5'(16 + f3);
            end else if (f7 == 7'h20) begin
                if (f3 == 3'd0 || f3 == 3'd5) e.alu = 5'(24 + f3);
                else e.ill = 1'b1;
            end else if (f7 == 7'h01) begin
                e.md  = 1'b1;
                e.mop = f3;
                e.n   = (f3 < 3'd4) ? MULC : DIVC;
            end else begin
                e.ill = 1'b1;
            end
        end else if (op == 7'h63) begin
            e.alu = 5'd24;
        end else if (op == 7'h67) begin
            e.alu = 5'd16;
        end
        return e;
    endfunction

    // Monitor: compares presented outputs against the scoreboard head
    int   stepidx = 0;
    bit   fresh = 1'b1;
    exp_t m;
    always @(negedge clk) begin
        if (!rst_n) begin
            stepidx = 0;
            fresh   = 1'b1;
        end else begin
            if (md_step) begin
                if (sb.size() == 0) begin
                    chk("step_without_txn", 1, 0);
                end else begin
                    chk("md_first", md_first, stepidx == 0);
                    chk("md_last", md_last, stepidx == sb[0].n - 1);
                end
                chk("in_ready_in_run", in_ready, 0);
                stepidx++;
            end else begin
                chk("md_first_idle", md_first, 0);
                chk("md_last_idle", md_last, 0);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("valid_without_txn", 1, 0);
                end else begin
                    m = sb[0];
                    if (fresh) begin
                        chk("latency", cyc - m.acc, 1 + m.n);
                        chk("step_count", stepidx, m.n);
                        fresh = 1'b0;
                    end
                    chk("alu_op", alu_op, m.alu);
                    chk("md_sel", md_sel, m.md);
                    chk("illegal", illegal, m.ill);
                    if (m.md) chk("md_op", md_op, m.mop);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        fresh   = 1'b1;
                        stepidx = 0;
                    end
                end
            end
`ifdef ALU_SEQ_FLUSH_EN
            if (flush) begin
                stepidx = 0;
                fresh   = 1'b1;
            end
`endif
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        int   t;
        bit   acc;
        exp_t e;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        in_valid = 1'b1;
        acc      = 1'b0;
        t        = 0;
        while (!acc) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(op, f3, f7);
                e.acc = cyc;
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 300) begin
                chk("issue_timeout", 0, 1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        in_valid = 1'b0;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", (t < 3000) ? 1 : 0, 1);
    endtask

    task automatic run_div_to_step10();
        int t;
        int steps;
        issue(7'h33, 3'd4, 7'h01);
        in_valid = 1'b0;
        steps = 0;
        t = 0;
        while (steps < 10 && t < 100) begin
            @(negedge clk);
            if (md_step) steps++;
            t++;
        end
        chk("reached_step10", steps, 10);
    endtask

    logic [6:0] ops[7];
    logic [6:0] f7s[4];

    initial begin
        int t;
        int c0;
        int vis;
        ops = '{7'h13, 7'h33, 7'h33, 7'h63, 7'h67, 7'h03, 7'h37};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_md_sel", md_sel, 0);
        chk("rst_md_op", md_op, 0);
        chk("rst_md_step", md_step, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SRA and MUL with consumer always ready
        out_ready = 1'b1;
        issue(7'h33, 3'd5, 7'h20);
        idle(2);
        issue(7'h33, 3'd0, 7'h01);
        idle(7);

        // DIVU held for 5 cycles by the consumer
        out_ready = 1'b0;
        issue(7'h33, 3'd5, 7'h01);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("divu_valid_seen", out_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("divu_consumed", out_valid, 0);

        // ADDI, XOR, BEQ back to back
        c0 = cyc;
        issue(7'h13, 3'd0, 7'h00);
        issue(7'h33, 3'd4, 7'h00);
        issue(7'h63, 3'd0, 7'h00);
        chk("b2b_cycles", cyc - c0, 3);
        idle(3);

        // Illegal encodings
        issue(7'h33, 3'd1, 7'h20);
        issue(7'h13, 3'd1, 7'h01);
        idle(3);

        // Random traffic
        rdy_mode = 1'b0;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                issue(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 4) == 0) ? 7'($urandom) :
                      f7s[$urandom_range(0, 3)]);
            end
        end
        drain();
        rdy_mode  = 1'b0;
        rdy_mode  = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Reset in the middle of a DIV
        run_div_to_step10();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_md_step", md_step, 0);
        chk("abort_md_sel", md_sel, 0);
        chk("abort_md_op", md_op, 0);
        chk("abort_busy", busy, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);

`ifdef ALU_SEQ_FLUSH_EN
        run_div_to_step10();
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_busy", busy, 0);
        chk("flush_md_step", md_step, 0);
        vis = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) vis++;
        end
        chk("flush_no_output", vis, 0);
        issue(7'h33, 3'd0, 7'h00);
        idle(3);
`else
        vis = 0;
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered successor to the combinational ALU-op decoder. It decodes opcode/funct3/funct7 into the 5-bit ALU operation and adds RV32M support. For MUL/DIV-class instructions it runs a parametrised multi-cycle step counter that drives the iterative multiply/divide datapath. It sits between the decode stage and the execute stage, with valid/ready handshakes on both sides, and provides the busy/stall source for the pipeline.

Parameters:
MUL_CYCLES, 4, number of md_step cycles for funct3 000-011 (MUL/MULH/MULHSU/MULHU); must be >=1
DIV_CYCLES, 32, number of md_step cycles for funct3 100-111 (DIV/DIVU/REM/REMU); must be >=1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  instruction accepted when in_valid && in_ready
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7  input  7  instruction[31:25]
out_valid  output  1  result fields valid to execute
out_ready  input  1  execute consumes when out_valid && out_ready
alu_op  output  5  {use_alu, alt, funct3}; 00000 means ALU out = input B
md_sel  output  1  result comes from the mul/div unit
md_op  output  3  mul/div funct3
md_step  output  1  advance the mul/div datapath one iteration
md_first  output  1  first step (load operands)
md_last  output  1  final step
illegal  output  1  undefined ALU-class encoding
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, alu_op, md_sel, md_op, md_step, md_first, md_last, illegal, and the counter all 0. Reset mid-sequence aborts immediately with no output.
- States: IDLE, MD_RUN, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational and gives back-to-back issue.
- Decode is applied at acceptance and registered:
  - opcode 0010011 (I-ALU): alu_op = {1, alt, funct3}. alt = funct7[5] only when funct3==101, else alt=0.
  - opcode 0110011 with funct7 0000000: {1,0,funct3}.
  - opcode 0110011 with funct7 0100000: {1,1,funct3}.
  - opcode 0110011 with funct7 0000001: M-extension, so md_sel=1, md_op=funct3, alu_op=00000.
  - opcode 1100011 (branch): 11000. opcode 1100111 (jalr): 10000. All other opcodes: 00000.
- illegal=1 and alu_op=00000 for any of:
  - R-type with any funct7 other than 0000000, 0100000 or 0000001.
  - R-type with funct7 0100000 and funct3 not 000/101.
  - I-type funct3 001 with funct7 != 0000000.
  - I-type funct3 101 with funct7 not in {0000000, 0100000}.
- Non-M instruction: IDLE->HOLD. out_valid rises the cycle after acceptance (latency 1).
- M instruction: IDLE->MD_RUN with cnt=0 and N = MUL_CYCLES or DIV_CYCLES.
  - In MD_RUN: md_step=1 every cycle; md_first=(cnt==0); md_last=(cnt==N-1); cnt increments each cycle.
  - After the md_last cycle: HOLD.
  - Timeline: accept at cycle T, steps at T+1..T+N, out_valid at T+N+1. N=1 gives md_first and md_last together.
- HOLD: out_valid=1 and all fields held stable until out_ready.
  - out_ready && in_valid: the new instruction is accepted in the same cycle (next state per its decode).
  - out_ready && !in_valid: go to IDLE and clear out_valid.
- MD_RUN ignores out_ready and in_valid (in_ready=0).
- The counter is sized to max(MUL_CYCLES, DIV_CYCLES) and never wraps. md_step/md_first/md_last are 0 outside MD_RUN.

Optional Feature:
ALU_SEQ_FLUSH_EN:
- Defined: adds input port flush (1 bit). flush=1 forces state to IDLE on the next edge from any state. It clears out_valid, md_step and the counter, and drops any instruction presented that cycle (in_ready is forced to 0 while flush=1). Flush has priority over all other transitions.
- Undefined: no flush port exists; behaviour is exactly as above.

Test Plan:
- Reset, then opcode 0110011, funct7 0100000, funct3 101 (SRA) with out_ready=1 -> out_valid one cycle after acceptance, alu_op=11101, illegal=0, md_sel=0.
- R-type funct7 0000001, funct3 000 (MUL), MUL_CYCLES=4 -> md_step high for exactly 4 cycles, md_first on the 1st and md_last on the 4th; out_valid with md_sel=1, md_op=000 on the next cycle.
- DIVU (funct3 101), DIV_CYCLES=32, out_ready held 0 for 5 cycles after out_valid -> 32 steps; in_ready=0 throughout; outputs stable while held; accepted on the first cycle out_ready=1.
- Back-to-back ADDI, XOR, BEQ with in_valid and out_ready constantly 1 -> in_ready=1 every cycle; alu_op sequence 10000, 10100, 11000 on consecutive cycles.
- R-type funct7 0100000, funct3 001 -> illegal=1, alu_op=00000; I-type funct3 001, funct7 0000001 -> illegal=1.
- rst_n pulsed low at step 10 of a DIV -> all outputs 0 immediately; in_ready=1 after release. With ALU_SEQ_FLUSH_EN defined, flush at step 10 -> IDLE next cycle, no out_valid.
